// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that feeds one UART transmitter from NUM_REQ byte producers.
// Transmitter occupancy is tracked purely by counting baud ticks after each start pulse.
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = 11,
    parameter int GAP_TICKS   = 1,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [NUM_REQ-1:0]   req_enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    if (NUM_REQ < 2 || NUM_REQ > 8 ||
        FRAME_TICKS < 1 || FRAME_TICKS > 15 ||
        GAP_TICKS < 0 || GAP_TICKS > 15) begin : g_cfg_err
        $error("uart_tx_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_GAP
    } state_e;

    localparam logic [3:0] FRAME_T = 4'(FRAME_TICKS);
    localparam logic [3:0] GAP_T   = 4'(GAP_TICKS);

    state_e           state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [7:0]       data_q, data_d;

    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IDW-1:0]     winner;
    logic [3:0]         tick_nxt;

    // First eligible index at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int idx;
        logic [IDW-1:0] idx_w;
        elig   = req_valid & req_enable;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = IDW'(idx);
            if (!found && elig[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    assign tick_nxt = tick_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        req_ready  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready = NUM_REQ'(1) << winner;
                    data_d    = req_data[8*winner +: 8];
                    grant_d   = winner;
                    if (int'(winner) == NUM_REQ - 1) rr_ptr_d = '0;
                    else rr_ptr_d = winner + 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (baud_tick) begin
                    if (tick_nxt == FRAME_T) begin
                        tick_cnt_d = '0;
                        state_d    = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
                    end else begin
                        tick_cnt_d = tick_nxt;
                    end
                end
            end
            S_GAP: begin
                if (baud_tick) begin
                    if (tick_nxt == GAP_T) begin
                        tick_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_nxt;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
        end
    end

    assign tx_start = (state_q == S_START);
    assign busy     = (state_q != S_IDLE);
    assign tx_data  = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default build plus a GAP_TICKS=0 build.
// Expected grants, bytes and tick counts are hand-computed per vector.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic        baud_tick;
    logic [3:0]  req_enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;

    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  req_ready0;
    logic        tx_start0;
    logic [7:0]  tx_data0;
    logic        busy0;
    logic [1:0]  grant_id0;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(11), .GAP_TICKS(1)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .req_enable(req_enable), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(11), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .req_enable(req_enable), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready0), .tx_start(tx_start0), .tx_data(tx_data0),
        .busy(busy0), .grant_id(grant_id0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        baud_tick  = 1'b0;
        req_valid  = 4'b0000;
        req_enable = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge of an IDLE cycle with the request applied.
    task automatic do_frame(input string tag, input logic [3:0] exp_rdy,
                            input logic [7:0] exp_dat, input int exp_id,
                            input bit keep, input bit st_tick, input bit chk0);
        int n;
        int n0;
        chk({tag, ".rdy"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, ".st_idle"}, 32'(tx_start), 0);
        @(posedge clk);
        #1;
        if (!keep) req_valid = req_valid & ~exp_rdy;
        baud_tick = st_tick;
        @(negedge clk);
        chk({tag, ".start"}, 32'(tx_start), 1);
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".data"}, 32'(tx_data), 32'(exp_dat));
        chk({tag, ".id"}, 32'(grant_id), exp_id);
        chk({tag, ".rdy_lo"}, 32'(req_ready), 0);
        @(posedge clk);
        #1 baud_tick = 1'b0;
        @(negedge clk);
        chk({tag, ".st_send"}, 32'(tx_start), 0);
        n  = 0;
        n0 = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
            @(negedge clk);
            n++;
            if (n0 == 0 && !busy0) n0 = n;
        end
        chk({tag, ".ticks"}, n, 12);
        if (chk0) chk({tag, ".ticks_gap0"}, n0, 11);
    endtask

    initial begin
        rst_n      = 1'b0;
        baud_tick  = 1'b0;
        req_valid  = 4'b0000;
        req_enable = 4'b1111;
        req_data   = 32'h0;

        // reset values
        do_reset();
        chk("rst.busy", 32'(busy), 0);
        chk("rst.start", 32'(tx_start), 0);
        chk("rst.data", 32'(tx_data), 0);
        chk("rst.id", 32'(grant_id), 0);
        chk("rst.rdy", 32'(req_ready), 0);
        chk("rst.busy0", 32'(busy0), 0);

        // single request, default byte
        @(posedge clk);
        #1;
        req_data  = 32'h000000A5;
        req_valid = 4'b0001;
        @(negedge clk);
        do_frame("t1", 4'b0001, 8'hA5, 0, 0, 0, 1);
        chk("t1.idle_rdy", 32'(req_ready), 0);

        // all valid: 0,1,2,3,0 with one IDLE cycle between frames
        do_reset();
        @(posedge clk);
        #1;
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        @(negedge clk);
        do_frame("rr0", 4'b0001, 8'h10, 0, 1, 0, 0);
        do_frame("rr1", 4'b0010, 8'h11, 1, 1, 0, 0);
        do_frame("rr2", 4'b0100, 8'h12, 2, 1, 0, 0);
        do_frame("rr3", 4'b1000, 8'h13, 3, 1, 0, 0);
        do_frame("rr4", 4'b0001, 8'h10, 0, 1, 0, 0);

        // wrap-around from rr_ptr=2, then rr_ptr must be 2
        do_reset();
        @(posedge clk);
        #1;
        req_data  = 32'h44332211;
        req_valid = 4'b0010;
        @(negedge clk);
        do_frame("wr_a", 4'b0010, 8'h22, 1, 0, 0, 0);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        @(negedge clk);
        do_frame("wr_b", 4'b0010, 8'h22, 1, 0, 0, 0);
        @(posedge clk);
        #1 req_valid = 4'b0111;
        @(negedge clk);
        do_frame("wr_c", 4'b0100, 8'h33, 2, 0, 0, 0);

        // requester 1 masked: 0,2,3,0
        do_reset();
        @(posedge clk);
        #1;
        req_data   = 32'hD4C3B2A1;
        req_enable = 4'b1101;
        req_valid  = 4'b1111;
        @(negedge clk);
        do_frame("en0", 4'b0001, 8'hA1, 0, 1, 0, 0);
        do_frame("en1", 4'b0100, 8'hC3, 2, 1, 0, 0);
        do_frame("en2", 4'b1000, 8'hD4, 3, 1, 0, 0);
        do_frame("en3", 4'b0001, 8'hA1, 0, 1, 0, 0);

        // tick during START is ignored
        do_reset();
        @(posedge clk);
        #1;
        req_data  = 32'hC3000000;
        req_valid = 4'b1000;
        @(negedge clk);
        do_frame("stk", 4'b1000, 8'hC3, 3, 0, 1, 1);

        // asynchronous reset in SEND
        do_reset();
        @(posedge clk);
        #1;
        req_data  = 32'h005A0077;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("mr.rdy", 32'(req_ready), 32'(4'b0100));
        @(posedge clk);
        #1 req_valid = 4'b0000;
        @(posedge clk);
        #1 baud_tick = 1'b1;
        @(posedge clk);
        #1 baud_tick = 1'b0;
        @(negedge clk);
        chk("mr.busy_pre", 32'(busy), 1);
        chk("mr.id_pre", 32'(grant_id), 2);
        chk("mr.data_pre", 32'(tx_data), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.busy", 32'(busy), 0);
        chk("mr.start", 32'(tx_start), 0);
        chk("mr.id", 32'(grant_id), 0);
        chk("mr.data", 32'(tx_data), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        do_frame("mr_post", 4'b0001, 8'h77, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
